// File: rtl/paicore_rx_monitor.sv
// Receive-side stream monitor: gates the SNN stream into the FIFO while receiving,
// counts beats/tlast/microseconds, and stops at a beat limit. Optional idle timeout: PAICORE_RX_TIMEOUT_EN.
module paicore_rx_monitor #(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned TIMEOUT_US   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataPath_Reset_n,
  input  logic        rx_rcving,
  input  logic [31:0] oFrameNumMax,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        snn2fifo_plus,
  output logic        rx_done,
  output logic [31:0] data_cnt,
  output logic [31:0] tlast_cnt,
  output logic [31:0] us_tick_num,
  output logic        timeout_flag
);

  // state | meaning
  // IDLE  | stream blocked, statistics hold their last values
  // RECV  | stream passes through, beats and microseconds counted
  // DONE  | limit (or timeout) reached, stream blocked until rx_rcving drops
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  localparam logic [9:0] PRESC_LAST = 10'(CLK_FREQ_MHZ - 1);

  state_t      state_q, state_d;
  logic        srst;
  logic        in_recv;
  logic        accept;
  logic        wrap;
  logic        limit_hit;
  logic        timeout_hit;
  logic        entry;
  logic [9:0]  presc_q;
  logic [31:0] data_next;

  // Soft reset also gates the stream combinationally so an in-flight beat is dropped.
  assign srst    = rst | ~DataPath_Reset_n;
  assign in_recv = (state_q == S_RECV) & ~srst;
  assign accept  = s_axis_tvalid & m_axis_tready & in_recv;
  assign wrap    = in_recv & (presc_q == PRESC_LAST);
  assign entry   = (state_q == S_IDLE) & rx_rcving;

  assign data_next = (accept && data_cnt != 32'hFFFF_FFFF) ? data_cnt + 32'd1 : data_cnt;
  // Compare against the post-increment count so a lowered limit fires on the next beat.
  assign limit_hit = accept & (oFrameNumMax != 32'd0) & (data_next >= oFrameNumMax);

`ifdef PAICORE_RX_TIMEOUT_EN
  logic [31:0] idle_us_q;
  logic        timeout_q;

  assign timeout_hit  = in_recv & ~accept & wrap & (data_cnt != 32'd0) &
                        (({1'b0, idle_us_q} + 33'd1) >= 33'(TIMEOUT_US));
  assign timeout_flag = timeout_q;

  always_ff @(posedge clk) begin
    if (srst || entry) begin
      idle_us_q <= '0;
      timeout_q <= 1'b0;
    end else if (in_recv) begin
      if (accept)
        idle_us_q <= '0;
      else if (wrap && data_cnt != 32'd0 && idle_us_q != 32'hFFFF_FFFF)
        idle_us_q <= idle_us_q + 32'd1;
      if (timeout_hit && state_d == S_DONE)
        timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit  = 1'b0;
  // The parameter stays on the interface so both builds share one instantiation.
  assign timeout_flag = 1'b0 & (TIMEOUT_US != 0);
`endif

  always_ff @(posedge clk) begin
    if (srst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rx_rcving) state_d = S_RECV;
      S_RECV: begin
        if (!rx_rcving)
          state_d = S_IDLE;
        else if (limit_hit || timeout_hit)
          state_d = S_DONE;
      end
      S_DONE: if (!rx_rcving) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = m_axis_tready & in_recv;
    m_axis_tvalid = s_axis_tvalid & in_recv;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tlast  = s_axis_tlast;
    snn2fifo_plus = accept;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      data_cnt    <= '0;
      tlast_cnt   <= '0;
      us_tick_num <= '0;
      presc_q     <= '0;
      rx_done     <= 1'b0;
    end else begin
      rx_done <= (state_d == S_DONE);
      if (entry) begin
        data_cnt    <= '0;
        tlast_cnt   <= '0;
        us_tick_num <= '0;
        presc_q     <= '0;
      end else if (in_recv) begin
        data_cnt <= data_next;
        if (accept && s_axis_tlast && tlast_cnt != 32'hFFFF_FFFF)
          tlast_cnt <= tlast_cnt + 32'd1;
        if (wrap) begin
          presc_q <= '0;
          if (us_tick_num != 32'hFFFF_FFFF)
            us_tick_num <= us_tick_num + 32'd1;
        end else begin
          presc_q <= presc_q + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_paicore_rx_monitor.sv
// Bench for paicore_rx_monitor: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_paicore_rx_monitor;

  localparam int unsigned CLK_MHZ = 10;
  localparam int unsigned TOUT_US = 2;

  logic        clk = 1'b0;
  logic        rst, DataPath_Reset_n, rx_rcving;
  logic [31:0] oFrameNumMax;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic        snn2fifo_plus, rx_done, timeout_flag;
  logic [31:0] data_cnt, tlast_cnt, us_tick_num;

  logic        h_s_tready, h_m_tvalid, h_m_tlast, h_plus, h_done, h_tout;
  logic [63:0] h_m_tdata;
  logic [31:0] h_data_cnt, h_tlast_cnt, h_us;

  always #5 clk = ~clk;

  paicore_rx_monitor #(.CLK_FREQ_MHZ(CLK_MHZ), .TIMEOUT_US(TOUT_US)) u_dut (
    .clk(clk), .rst(rst), .DataPath_Reset_n(DataPath_Reset_n), .rx_rcving(rx_rcving),
    .oFrameNumMax(oFrameNumMax),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .snn2fifo_plus(snn2fifo_plus), .rx_done(rx_done), .data_cnt(data_cnt),
    .tlast_cnt(tlast_cnt), .us_tick_num(us_tick_num), .timeout_flag(timeout_flag)
  );

  // Second instance at 100 MHz, used only for the microsecond-tick literal.
  paicore_rx_monitor #(.CLK_FREQ_MHZ(100)) u_dut100 (
    .clk(clk), .rst(rst), .DataPath_Reset_n(DataPath_Reset_n), .rx_rcving(rx_rcving),
    .oFrameNumMax(oFrameNumMax),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(h_s_tready),
    .m_axis_tdata(h_m_tdata), .m_axis_tvalid(h_m_tvalid), .m_axis_tlast(h_m_tlast),
    .m_axis_tready(m_axis_tready),
    .snn2fifo_plus(h_plus), .rx_done(h_done), .data_cnt(h_data_cnt),
    .tlast_cnt(h_tlast_cnt), .us_tick_num(h_us), .timeout_flag(h_tout)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: receiving/done flags, counts, and cycles spent receiving.
  bit          m_recv = 0, m_done = 0, m_tout = 0;
  logic [31:0] m_data = '0, m_tlast = '0;
  int unsigned m_rc = 0;
  int unsigned m_lb = 0;

  task automatic model_cycle();
    bit srst, e_in, e_rdy, e_val, e_acc, lim, tmo;
    logic [31:0] nd;
    srst  = rst || !DataPath_Reset_n;
    e_in  = m_recv && !srst;
    e_rdy = m_axis_tready && e_in;
    e_val = s_axis_tvalid && e_in;
    e_acc = e_val && e_rdy;
    chk("tready", s_axis_tready, e_rdy);
    chk("tvalid", m_axis_tvalid, e_val);
    chk("plus", snn2fifo_plus, e_acc);
    chk("tdata", m_axis_tdata, s_axis_tdata);
    chk("tlast", m_axis_tlast, s_axis_tlast);
    chk("rx_done", rx_done, m_done);
    chk("data_cnt", data_cnt, m_data);
    chk("tlast_cnt", tlast_cnt, m_tlast);
    chk("us_tick", us_tick_num, m_rc / CLK_MHZ);
    chk("timeout_flag", timeout_flag, m_tout);
    if (srst) begin
      m_recv = 0; m_done = 0; m_tout = 0; m_data = '0; m_tlast = '0; m_rc = 0; m_lb = 0;
    end else if (m_recv) begin
      nd = (e_acc && m_data != 32'hFFFF_FFFF) ? m_data + 1 : m_data;
      if (e_acc && s_axis_tlast && m_tlast != 32'hFFFF_FFFF) m_tlast = m_tlast + 1;
      m_rc++;
      if (e_acc) m_lb = m_rc;
      lim = e_acc && oFrameNumMax != 0 && nd >= oFrameNumMax;
      tmo = 0;
`ifdef PAICORE_RX_TIMEOUT_EN
      tmo = !e_acc && m_data != 0 && (m_rc % CLK_MHZ) == 0 &&
            (m_rc / CLK_MHZ - m_lb / CLK_MHZ) >= TOUT_US;
`endif
      m_data = nd;
      if (!rx_rcving) m_recv = 0;
      else if (lim) begin m_recv = 0; m_done = 1; end
      else if (tmo) begin m_recv = 0; m_done = 1; m_tout = 1; end
    end else if (m_done) begin
      if (!rx_rcving) m_done = 0;
    end else if (rx_rcving) begin
      m_recv = 1; m_data = '0; m_tlast = '0; m_rc = 0; m_lb = 0; m_tout = 0;
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_cycle();
    end
  end

  initial begin
    int plus_n, sent;
    bit mirror_ok;
    logic [63:0] q[$];

    rst = 1; DataPath_Reset_n = 1; rx_rcving = 1; oFrameNumMax = 0;
    s_axis_tdata = '0; s_axis_tvalid = 1; s_axis_tlast = 0; m_axis_tready = 1;
    repeat (3) tick();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_plus", snn2fifo_plus, 0);
    chk("rst_cnt", data_cnt, 0);
    chk("rst_done", rx_done, 0);
    rst = 0; rx_rcving = 0; s_axis_tvalid = 0;
    tick();

    // limit of 4 beats
    oFrameNumMax = 4; rx_rcving = 1; tick();
    plus_n = 0;
    for (int b = 1; b <= 6; b++) begin
      s_axis_tvalid = 1; s_axis_tdata = 64'(b); s_axis_tlast = (b == 4);
      #1;
      if (snn2fifo_plus) plus_n++;
      if (b == 5) begin
        chk("lim_done_next", rx_done, 1);
        chk("lim_beat5", snn2fifo_plus, 0);
      end
      tick();
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    chk("lim_pulses", plus_n, 4);
    chk("lim_cnt", data_cnt, 4);
    chk("lim_tlast", tlast_cnt, 1);
    rx_rcving = 0; tick();
    chk("lim_idle_done", rx_done, 0);

    // backpressure
    oFrameNumMax = 3; rx_rcving = 1; tick();
    sent = 0; mirror_ok = 1;
    for (int i = 0; i < 10; i++) begin
      m_axis_tready = (i % 2 == 0); s_axis_tvalid = 1; s_axis_tdata = 64'(100 + sent);
      #1;
      if (sent < 3 && s_axis_tready !== m_axis_tready) mirror_ok = 0;
      if (m_axis_tvalid && m_axis_tready) begin q.push_back(m_axis_tdata); sent++; end
      tick();
    end
    s_axis_tvalid = 0; m_axis_tready = 1;
    chk("bp_mirror", mirror_ok, 1);
    chk("bp_cnt", data_cnt, 3);
    chk("bp_qsize", q.size(), 3);
    for (int k = 0; k < q.size(); k++) chk("bp_data", q[k], 64'(100 + k));
    rx_rcving = 0; tick();

    // microsecond ticks
    rx_rcving = 1; tick();
    repeat (1000) tick();
    chk("tick_us100", h_us, 10);
    chk("tick_us10", us_tick_num, 100);
    rx_rcving = 0; tick();
    chk("tick_idle_rdy", s_axis_tready, 0);
    chk("tick_hold100", h_us, 10);
    chk("tick_hold10", us_tick_num, 100);

    // abort and soft reset
    oFrameNumMax = 0; rx_rcving = 1; tick();
    s_axis_tvalid = 1; tick(); tick();
    s_axis_tvalid = 0; rx_rcving = 0; tick();
    chk("abort_cnt", data_cnt, 2);
    chk("abort_done", rx_done, 0);
    chk("abort_rdy", s_axis_tready, 0);
    rx_rcving = 1; tick();
    chk("reen_cnt", data_cnt, 0);
    s_axis_tvalid = 1; tick(); tick();
    chk("sr_pre_cnt", data_cnt, 2);
    DataPath_Reset_n = 0; #1;
    chk("sr_plus", snn2fifo_plus, 0);
    chk("sr_rdy", s_axis_tready, 0);
    tick();
    chk("sr_cnt", data_cnt, 0);
    DataPath_Reset_n = 1; s_axis_tvalid = 0; #1;
    chk("sr_rdy_after", s_axis_tready, 0);
    tick();
    rx_rcving = 0; tick();

    // idle timeout
    oFrameNumMax = 0; rx_rcving = 1; tick();
    s_axis_tvalid = 1; tick();
    s_axis_tvalid = 0;
    repeat (20) tick();
    chk("tmo_cnt", data_cnt, 1);
`ifdef PAICORE_RX_TIMEOUT_EN
    chk("tmo_done", rx_done, 1);
    chk("tmo_flag", timeout_flag, 1);
`else
    chk("tmo_done", rx_done, 0);
    chk("tmo_flag", timeout_flag, 0);
    chk("tmo_recv", s_axis_tready, 1);
`endif
    rx_rcving = 0; tick();

    // unlimited, then a lowered limit
    oFrameNumMax = 0; rx_rcving = 1; tick();
    s_axis_tvalid = 1; repeat (10) tick();
    s_axis_tvalid = 0; #1;
    chk("unl_cnt", data_cnt, 10);
    chk("unl_recv", s_axis_tready, 1);
    chk("unl_done", rx_done, 0);
    oFrameNumMax = 5; s_axis_tvalid = 1; tick();
    s_axis_tvalid = 0;
    chk("chg_done", rx_done, 1);
    chk("chg_cnt", data_cnt, 11);
    rx_rcving = 0; tick();

    // limit beat on the same cycle as abort
    oFrameNumMax = 1; rx_rcving = 1; tick();
    rx_rcving = 0; s_axis_tvalid = 1; tick();
    s_axis_tvalid = 0; #1;
    chk("same_cnt", data_cnt, 1);
    chk("same_done", rx_done, 0);
    chk("same_rdy", s_axis_tready, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) < 3) rx_rcving = ~rx_rcving;
      rst = ($urandom_range(0, 299) == 0);
      DataPath_Reset_n = ($urandom_range(0, 299) != 0);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = ($urandom_range(0, 3) == 0);
      s_axis_tdata  = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) oFrameNumMax = $urandom_range(0, 20);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/paicore_rx_monitor.md
PAICORE_RX_MONITOR -- requirements
Module: paicore_rx_monitor

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_MHZ, default 100, giving clock cycles per microsecond (legal range 1..1023).
REQ-002 The module SHALL have parameter TIMEOUT_US, default 1000, giving the idle-timeout in microseconds (used only when PAICORE_RX_TIMEOUT_EN is defined).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port DataPath_Reset_n, input, 1 bit: soft reset from the register file, synchronous and active-low.
REQ-006 The module SHALL have port rx_rcving, input, 1 bit: receive-enable level from the register file.
REQ-007 The module SHALL have port oFrameNumMax, input, 32 bits: beat limit per receive; 0 means unlimited.
REQ-008 The module SHALL have ports s_axis_tdata (input, 64 bits), s_axis_tvalid (input, 1 bit), s_axis_tlast (input, 1 bit) and s_axis_tready (output, 1 bit): the SNN-side stream.
REQ-009 The module SHALL have ports m_axis_tdata (output, 64 bits), m_axis_tvalid (output, 1 bit), m_axis_tlast (output, 1 bit) and m_axis_tready (input, 1 bit): the FIFO-side stream.
REQ-010 The module SHALL have port snn2fifo_plus, output, 1 bit: one-cycle pulse per accepted beat.
REQ-011 The module SHALL have port rx_done, output, 1 bit: level, high in DONE.
REQ-012 The module SHALL have ports data_cnt (output, 32 bits), tlast_cnt (output, 32 bits) and us_tick_num (output, 32 bits): statistics for the register file.
REQ-013 The module SHALL have port timeout_flag, output, 1 bit: high in DONE if DONE was entered by timeout.

Function
REQ-014 The FSM SHALL have states IDLE, RECV and DONE, with the state held in a register.
REQ-015 IDLE->RECV SHALL occur on the cycle rx_rcving is sampled high; entry clears data_cnt, tlast_cnt, us_tick_num, timeout_flag and the sub-microsecond prescaler.
REQ-016 RECV->DONE SHALL occur the cycle after the beat that makes data_cnt equal oFrameNumMax (oFrameNumMax != 0) is accepted.
REQ-017 RECV->IDLE SHALL occur when rx_rcving is sampled low (abort); the counters hold their values.
REQ-018 DONE->IDLE SHALL occur when rx_rcving is sampled low; DONE holds otherwise.
REQ-019 Gating SHALL be combinational with zero latency: m_axis_tvalid = s_axis_tvalid AND (state==RECV); s_axis_tready = m_axis_tready AND (state==RECV); tdata and tlast pass straight through.
REQ-020 A beat SHALL be accepted when s_axis_tvalid, s_axis_tready and state==RECV are all high; snn2fifo_plus equals the acceptance condition on that same cycle.
REQ-021 Each accepted beat SHALL add 1 to data_cnt, and additionally add 1 to tlast_cnt if s_axis_tlast is high; both counters saturate at 0xFFFFFFFF.
REQ-022 In RECV the prescaler SHALL count 0..CLK_FREQ_MHZ-1, and us_tick_num SHALL increment (saturating) on each wrap; us_tick_num freezes in DONE and IDLE.
REQ-023 When the limit beat is accepted, no further beat SHALL be accepted: tready drops on the next cycle because the state is DONE.
REQ-024 If the limit beat is accepted on the same cycle rx_rcving falls, the FSM SHALL go to IDLE, and data_cnt SHALL include that beat.
REQ-025 If data_cnt saturates while oFrameNumMax is 0, the FSM SHALL stay in RECV.
REQ-026 A change of oFrameNumMax during RECV SHALL take effect immediately; if data_cnt is already at or above the new non-zero value, the next accepted beat (or the current one, if accepted) SHALL trigger DONE.
REQ-027 rx_done SHALL be a registered level equal to (state==DONE); the downstream register file edge-detects it.

Reset
REQ-028 Reset SHALL be the condition (rst OR NOT DataPath_Reset_n), sampled synchronously; it forces IDLE, all counters 0, timeout_flag 0 and rx_done 0.
REQ-029 During and after reset, s_axis_tready, m_axis_tvalid and snn2fifo_plus SHALL be 0.
REQ-030 Reset asserted mid-RECV SHALL discard the in-flight beat, and the counters SHALL read 0 on the following cycle.

Configuration
REQ-031 With macro PAICORE_RX_TIMEOUT_EN defined, once data_cnt is at least 1 in RECV, an idle-microsecond counter SHALL clear on every accepted beat and increment on each prescaler wrap; reaching TIMEOUT_US SHALL cause RECV->DONE with timeout_flag=1.
REQ-032 Without PAICORE_RX_TIMEOUT_EN, the timeout logic SHALL be absent, timeout_flag SHALL be tied to 0, and DONE SHALL be reached only via the limit.

Verification
REQ-033 Limit case: oFrameNumMax=4, rx_rcving=1, continuous valid/ready, tlast on beat 4 -> 4 snn2fifo_plus pulses, data_cnt=4, tlast_cnt=1, rx_done=1 on the cycle after beat 4, and beat 5 not accepted.
REQ-034 Backpressure case: oFrameNumMax=3, m_axis_tready toggling 1010... -> s_axis_tready mirrors it, data_cnt=3, and no data loss or duplication on m_axis.
REQ-035 Tick case: CLK_FREQ_MHZ=100, RECV held for 1000 cycles with no data -> us_tick_num=10; after dropping rx_rcving -> IDLE with us_tick_num still 10.
REQ-036 Abort and soft-reset case: abort after 2 beats (rx_rcving 0) -> IDLE, data_cnt=2, rx_done never high; re-enable -> counters 0. Pulsing DataPath_Reset_n low mid-RECV -> counters 0 and tready 0 on the next cycle.
REQ-037 Timeout case (macro defined, TIMEOUT_US=2, CLK_FREQ_MHZ=10): 1 beat, then idle for 20 cycles -> DONE with timeout_flag=1 and data_cnt=1. Macro undefined -> remains in RECV.
REQ-038 Unlimited case: oFrameNumMax=0 with 10 beats -> data_cnt=10 and still in RECV.
